// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start-bit detect, 1..8 data bits MSB-first, stop-bit check,
// assembled word held in a valid/ready output register with framing/overrun pulses.
module serial_frame_rx #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         si,
  input  logic [3:0]   len,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    STOP  = 2'd2
  } state_t;

  state_t       state, state_next;
  logic [3:0]   cnt;
  logic [W-1:0] shreg;
  logic [3:0]   eff_len;
  logic         start_det;
  logic         good_stop;
  logic         load_word;

  assign eff_len = (len == 4'd0 || len > 4'd8) ? 4'd8 : len;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    good_stop  = 1'b0;
    load_word  = 1'b0;
    unique case (state)
      IDLE: begin
        start_det = en && !si;
        if (start_det) state_next = SHIFT;
      end
      SHIFT: begin
        if (cnt == 4'd1) state_next = STOP;
      end
      STOP: begin
        good_stop  = si;
        // A consumer taking the held word on this edge frees the slot for the new one.
        load_word  = si && (!out_valid || out_ready);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      shreg <= '0;
    end else if (start_det) begin
      cnt   <= eff_len;
      shreg <= '0;
    end else if (state == SHIFT) begin
      cnt   <= cnt - 4'd1;
      shreg <= {shreg[W-2:0], si};
    end
  end

  // shreg starts cleared, so after eff_len shifts its upper bits are already zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= (state == STOP) && !si;
      overrun   <= good_stop && !load_word;
      if (load_word) begin
        out_data  <= shreg;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Self-checking bench for serial_frame_rx: table-driven frames plus hand sequences for
// overrun, same-edge consume/complete, en drop and mid-frame reset; words checked via a scoreboard.
module tb_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       si;
  logic [3:0] len;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0] len;
    int         nbits;
    logic [7:0] data;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[7];

  serial_frame_rx #(.W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .si(si), .len(len),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and hold through the next one.
  task automatic drive(input logic v);
    si = v;
    @(posedge clk);
    #1;
    busy_cnt += int'(busy);
  endtask

  // Start bit plus data bits, first bit sent is the MSB of the n-bit field; len is scrambled
  // after the start edge since the DUT must have latched it already.
  task automatic send_bits(input logic [3:0] len_v, input int n, input logic [7:0] data);
    busy_cnt = 0;
    len = len_v;
    drive(1'b0);
    len = len_v ^ 4'h5;
    for (int i = n - 1; i >= 0; i--) drive(data[i]);
  endtask

  // Scoreboard: a word is consumed at the next rising edge when valid & ready are seen here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", {24'h0, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        check("sb_word", {24'h0, out_data}, {24'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd8,  8, 8'hB6, 1'b1, 8'hB6, 1'b0};
    vecs[1] = '{4'd3,  3, 8'h06, 1'b1, 8'h06, 1'b0};
    vecs[2] = '{4'd0,  8, 8'h5A, 1'b1, 8'h5A, 1'b0};
    vecs[3] = '{4'd12, 8, 8'hC3, 1'b1, 8'hC3, 1'b0};
    vecs[4] = '{4'd1,  1, 8'h01, 1'b1, 8'h01, 1'b0};
    vecs[5] = '{4'd8,  8, 8'h77, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{4'd5,  5, 8'h13, 1'b1, 8'h13, 1'b0};

    rst = 1'b1; en = 1'b1; si = 1'b1; len = 4'd8; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_data",  {24'h0, out_data}, 32'h0);
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy",      {31'h0, busy}, 32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_overrun",   {31'h0, overrun}, 32'h0);
    rst = 1'b0;
    drive(1'b1);
    drive(1'b1);

    for (int i = 0; i < 7; i++) begin
      send_bits(vecs[i].len, vecs[i].nbits, vecs[i].data);
      if (vecs[i].stop) sb.push_back(vecs[i].exp_data);
      drive(vecs[i].stop);
      check($sformatf("v%0d_frame_err", i), {31'h0, frame_err}, {31'h0, vecs[i].exp_ferr});
      check($sformatf("v%0d_out_valid", i), {31'h0, out_valid}, {31'h0, !vecs[i].exp_ferr});
      if (!vecs[i].exp_ferr)
        check($sformatf("v%0d_out_data", i), {24'h0, out_data}, {24'h0, vecs[i].exp_data});
      check($sformatf("v%0d_busy_cycles", i), busy_cnt, vecs[i].nbits + 1);
      check($sformatf("v%0d_busy_end", i), {31'h0, busy}, 32'h0);
      drive(1'b1);
      check($sformatf("v%0d_ferr_pulse", i), {31'h0, frame_err}, 32'h0);
      check($sformatf("v%0d_valid_drop", i), {31'h0, out_valid}, 32'h0);
      check($sformatf("v%0d_no_false_start", i), {31'h0, busy}, 32'h0);
    end

    // en low in IDLE: a 0 on si must not start a frame.
    en = 1'b0;
    repeat (3) drive(1'b0);
    check("en_low_idle", {31'h0, busy}, 32'h0);
    si = 1'b1;
    en = 1'b1;
    drive(1'b1);

    // en dropped after the start bit: frame still completes.
    busy_cnt = 0;
    len = 4'd8;
    drive(1'b0);
    en = 1'b0;
    for (int i = 7; i >= 0; i--) drive(8'h96 >> i);
    sb.push_back(8'h96);
    drive(1'b1);
    check("en_drop_valid", {31'h0, out_valid}, 32'h1);
    check("en_drop_data", {24'h0, out_data}, 32'h96);
    en = 1'b1;
    drive(1'b1);

    // Overrun: consumer stalled across two back-to-back frames.
    out_ready = 1'b0;
    send_bits(4'd8, 8, 8'hA5);
    sb.push_back(8'hA5);
    drive(1'b1);
    check("ovr_first_valid", {31'h0, out_valid}, 32'h1);
    check("ovr_first_data", {24'h0, out_data}, 32'hA5);
    check("ovr_first_pulse", {31'h0, overrun}, 32'h0);
    send_bits(4'd8, 8, 8'h3C);
    drive(1'b1);
    check("ovr_pulse", {31'h0, overrun}, 32'h1);
    check("ovr_held_data", {24'h0, out_data}, 32'hA5);
    check("ovr_held_valid", {31'h0, out_valid}, 32'h1);
    check("ovr_no_ferr", {31'h0, frame_err}, 32'h0);
    drive(1'b1);
    check("ovr_pulse_end", {31'h0, overrun}, 32'h0);
    check("ovr_still_held", {24'h0, out_data}, 32'hA5);
    out_ready = 1'b1;
    drive(1'b1);
    check("ovr_drain_valid", {31'h0, out_valid}, 32'h0);

    // Consume and complete on the same edge.
    out_ready = 1'b0;
    send_bits(4'd8, 8, 8'hA5);
    sb.push_back(8'hA5);
    drive(1'b1);
    drive(1'b1);
    send_bits(4'd8, 8, 8'h3C);
    sb.push_back(8'h3C);
    out_ready = 1'b1;
    drive(1'b1);
    check("same_edge_valid", {31'h0, out_valid}, 32'h1);
    check("same_edge_data", {24'h0, out_data}, 32'h3C);
    check("same_edge_no_ovr", {31'h0, overrun}, 32'h0);
    drive(1'b1);
    check("same_edge_drain", {31'h0, out_valid}, 32'h0);

    // Reset during SHIFT with a word held: everything clears asynchronously.
    out_ready = 1'b0;
    send_bits(4'd8, 8, 8'h5A);
    drive(1'b1);
    check("pre_rst_held", {31'h0, out_valid}, 32'h1);
    len = 4'd8;
    drive(1'b0);
    drive(1'b1);
    drive(1'b0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'h0, out_valid}, 32'h0);
    check("arst_out_data", {24'h0, out_data}, 32'h0);
    check("arst_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    si = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send_bits(4'd8, 8, 8'h69);
    sb.push_back(8'h69);
    drive(1'b1);
    check("post_rst_valid", {31'h0, out_valid}, 32'h1);
    check("post_rst_data", {24'h0, out_data}, 32'h69);
    drive(1'b1);
    drive(1'b1);

    check("sb_empty", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
